// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - shares one main-memory port between the I-cache and the D-cache
module mem_bus_arbiter #(
    parameter int ADDR_W      = 28,
    parameter int DATA_W      = 128,
    parameter int D_MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [1:0]        gnt
);

    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, DONE} state_t;

    localparam int             BW        = $clog2(D_MAX_BURST + 1);
    localparam logic [BW-1:0]  BURST_MAX = BW'(D_MAX_BURST);

    state_t        state, state_nxt;
    logic [BW-1:0] burst_cnt;
    logic          d_req;
    logic          grant_i;
    logic          grant_d;

    // Grant decision: D-cache wins unless it has used up its burst while the I-cache waits
    always_comb begin
        d_req   = d_read | d_write;
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (state == IDLE) begin
            if (i_read && (!d_req || burst_cnt == BURST_MAX)) begin
                grant_i = 1'b1;
            end else if (d_req) begin
                grant_d = 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a completed transaction always takes one idle turnaround cycle
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant_i) begin
                    state_nxt = SERVE_I;
                end else if (grant_d) begin
                    state_nxt = SERVE_D;
                end
            end
            SERVE_I, SERVE_D: begin
                if (mem_ready) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs: owner indication and same-cycle ready routed to the owning cache only
    always_comb begin
        gnt     = 2'b00;
        i_ready = 1'b0;
        d_ready = 1'b0;
        case (state)
            SERVE_I: begin
                gnt     = 2'b01;
                i_ready = mem_ready;
            end
            SERVE_D: begin
                gnt     = 2'b10;
                d_ready = mem_ready;
            end
            default: ;
        endcase
    end

    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;

    // Registered memory command and saturating D-burst counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            burst_cnt <= '0;
        end else begin
            if (grant_i) begin
                mem_read  <= 1'b1;
                mem_write <= 1'b0;
                mem_addr  <= i_addr;
                burst_cnt <= '0;
            end else if (grant_d) begin
                // A simultaneous read and write is treated as a write-back
                mem_read  <= ~d_write;
                mem_write <= d_write;
                mem_addr  <= d_addr;
                if (d_write) begin
                    mem_wdata <= d_wdata;
                end
                if (!i_read) begin
                    burst_cnt <= '0;
                end else if (burst_cnt != BURST_MAX) begin
                    burst_cnt <= burst_cnt + BW'(1);
                end
            end else if ((state == SERVE_I || state == SERVE_D) && mem_ready) begin
                mem_read  <= 1'b0;
                mem_write <= 1'b0;
            end
        end
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single main-memory port between the I-cache (read-only) and the D-cache (read/write) in the pipelined MIPS system.
- Serialises miss-fill and write-back transactions, registers every memory-side command, and routes `mem_ready` back to the owning cache only.
- A bounded-priority scheme favours the D-cache but guarantees I-cache forward progress.
- Sits between the two caches and the slow memory model driven by the TestBed.

Parameters:
- ADDR_W, 28, block address width (word address >> 2).
- DATA_W, 128, cache line width.
- D_MAX_BURST, 4, max consecutive D-cache grants while an I-cache request waits.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- i_read  input  1  I-cache line-fill request, held until i_ready.
- i_addr  input  ADDR_W  I-cache line address.
- i_rdata  output  DATA_W  line data to I-cache; equals mem_rdata.
- i_ready  output  1  one-cycle completion pulse to I-cache.
- d_read  input  1  D-cache line-fill request.
- d_write  input  1  D-cache write-back request.
- d_addr  input  ADDR_W  D-cache line address.
- d_wdata  input  DATA_W  D-cache write-back data.
- d_rdata  output  DATA_W  line data to D-cache; equals mem_rdata.
- d_ready  output  1  one-cycle completion pulse to D-cache.
- mem_read  output  1  memory read command, registered.
- mem_write  output  1  memory write command, registered.
- mem_addr  output  ADDR_W  registered memory address.
- mem_wdata  output  DATA_W  registered write data.
- mem_rdata  input  DATA_W  memory read data, valid with mem_ready.
- mem_ready  input  1  memory completion pulse.
- gnt  output  2  current owner: 00 none, 01 I-cache, 10 D-cache.

Behaviour:
- Reset: state IDLE. mem_read, mem_write, i_ready, d_ready = 0. mem_addr, mem_wdata, burst count = 0. gnt = 00.
- States:
  - IDLE: grant decision.
  - SERVE_I: owner is the I-cache.
  - SERVE_D: owner is the D-cache.
  - DONE: one-cycle turnaround; no grants and no memory command.
- Grant decision in IDLE, evaluated at the rising edge:
  - D request only: go to SERVE_D.
  - I request only: go to SERVE_I.
  - Both pending: go to SERVE_I if burst count == D_MAX_BURST, else SERVE_D.
  - D request means d_read | d_write.
  - At that same edge, latch the owner's address into mem_addr. For d_write, also latch d_wdata into mem_wdata.
  - At that same edge, set mem_read or mem_write.
- d_read and d_write both high: treat as a write; mem_write = 1, mem_read = 0.
- Latency: request sampled at edge N gives mem_read/mem_write = 1 from after edge N to the edge where mem_ready = 1.
  - Memory command and address are stable for the whole transaction.
  - Requester inputs are ignored once a grant is made.
- Completion: in SERVE_x, the owner's ready = mem_ready, combinational and same cycle.
  - The other ready stays 0.
  - i_rdata and d_rdata always equal mem_rdata.
  - At the edge where mem_ready = 1: clear mem_read and mem_write, go to DONE.
- DONE always returns to IDLE after one cycle. Requesters drop their request at the edge after ready, so no stale re-grant is possible.
- Burst count (saturating 0..D_MAX_BURST):
  - Increments on each D grant made while i_read = 1.
  - Clears on any I grant.
  - Clears on any D grant made while i_read = 0.
- mem_ready outside SERVE_x: ignored; no ready pulse is generated.
- gnt = 01 in SERVE_I, 10 in SERVE_D, 00 in IDLE and DONE.
- Reset asserted mid-transaction: immediate return to reset values and any pending command is dropped. The memory model is reset in the same event.

Test Plan:
- Reset, then i_read = 1 with i_addr = 0x0000010.
  - Expected: next edge gives mem_read = 1, mem_addr = 0x0000010, gnt = 01.
  - After the memory returns mem_ready with mem_rdata = 0xDEADBEEF...: i_ready = 1 that cycle, d_ready = 0.
  - Then DONE, then IDLE.
- d_write = 1 with d_addr = 0x0000020 and d_wdata = 0x0123...CDEF.
  - Expected: mem_write = 1, mem_addr = 0x0000020, mem_wdata latched.
  - Changing d_wdata mid-transaction does not alter mem_wdata.
- Simultaneous i_read and d_read, D-cache re-requesting after every completion.
  - Expected: 4 D grants, then 1 I grant, then burst count 0.
- d_read and d_write both asserted.
  - Expected: mem_write = 1, mem_read = 0.
- Spurious mem_ready = 1 while in IDLE.
  - Expected: no i_ready or d_ready pulse, state unchanged.
- rst pulsed high while in SERVE_D waiting for memory.
  - Expected: mem_read, mem_write = 0 and gnt = 00 immediately (asynchronous).
  - After release, a new i_read is granted normally.
